// File: rtl/vec_issue_sequencer.sv
// Vector issue sequencer: decode, scoreboard hazard check, two-beat lane issue.
// Optional perf counters built when VSEQ_PERF_CNT_EN is defined.
module vec_issue_sequencer #(
    parameter int VLEN   = 32,
    parameter int VLANES = 16,
    parameter int NREG   = 4,
    parameter int WB_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst,
    output logic            lane_valid,
    output logic            lane_beat,
    output logic [2:0]      lane_op,
    output logic [1:0]      lane_vs1,
    output logic [1:0]      lane_vs2,
    output logic [1:0]      lane_vd,
    output logic            wb_valid,
    output logic [1:0]      wb_vd,
    output logic            wb_beat,
    output logic            illegal,
    output logic [2:0]      f_d_cycle,
    output logic [NREG-1:0] busy_vec,
    output logic [15:0]     issue_cnt,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ISSUE0 = 3'd2,
        ISSUE1 = 3'd3
    } state_t;

    localparam logic LAST_BEAT = 1'(VLEN / VLANES - 1);

    state_t state;
    logic [2:0] op_q;
    logic [1:0] vs1_q, vs2_q, vd_q;
    logic legal, hazard;
    logic [NREG-1:0] set_mask, clr_mask;
    logic [WB_LAT-1:0] pv, pb;
    logic [WB_LAT-1:0][1:0] pvd;
    logic unused_bits;

    assign unused_bits = ^inst[31:25];

    assign legal = (inst[6:0] == 7'b1010111) && (inst[11:9] == 3'd0)
                && (inst[19:17] == 3'd0) && (inst[24:22] == 3'd0);

    assign hazard = busy_vec[vs1_q] | busy_vec[vs2_q] | busy_vec[vd_q];

    assign inst_ready = (state == IDLE);
    assign f_d_cycle  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            illegal    <= 1'b0;
            lane_valid <= 1'b0;
            lane_beat  <= 1'b0;
            lane_op    <= '0;
            lane_vs1   <= '0;
            lane_vs2   <= '0;
            lane_vd    <= '0;
            op_q       <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            vd_q       <= '0;
        end else begin
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (inst_valid) begin
                        if (legal) begin
                            op_q  <= inst[14:12];
                            vs1_q <= inst[16:15];
                            vs2_q <= inst[21:20];
                            vd_q  <= inst[8:7];
                            state <= CHECK;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (!hazard) begin
                        state      <= ISSUE0;
                        lane_valid <= 1'b1;
                        lane_beat  <= 1'b0;
                        lane_op    <= op_q;
                        lane_vs1   <= vs1_q;
                        lane_vs2   <= vs2_q;
                        lane_vd    <= vd_q;
                    end
                end
                ISSUE0: begin
                    state     <= ISSUE1;
                    lane_beat <= LAST_BEAT;
                end
                default: begin
                    state      <= IDLE;
                    lane_valid <= 1'b0;
                end
            endcase
        end
    end

    // Set and clear target different registers (WAW check), so both apply.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (state == ISSUE0)
            set_mask[lane_vd] = 1'b1;
        if (wb_valid && wb_beat == LAST_BEAT)
            clr_mask[wb_vd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_vec <= '0;
        else
            busy_vec <= (busy_vec | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv  <= '0;
            pb  <= '0;
            pvd <= '0;
        end else begin
            for (int i = WB_LAT - 1; i > 0; i--) begin
                pv[i]  <= pv[i-1];
                pb[i]  <= pb[i-1];
                pvd[i] <= pvd[i-1];
            end
            pv[0]  <= lane_valid;
            pb[0]  <= lane_beat;
            pvd[0] <= lane_vd;
        end
    end

    assign wb_valid = pv[WB_LAT-1];
    assign wb_beat  = pb[WB_LAT-1];
    assign wb_vd    = pvd[WB_LAT-1];

`ifdef VSEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == ISSUE0 && issue_cnt != 16'hFFFF)
                issue_cnt <= issue_cnt + 16'd1;
            if (state == CHECK && hazard && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign issue_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/vec_issue_sequencer.md
# vec_issue_sequencer

Issue sequencer for the vector processor. Accepts one decoded OP-V instruction at a time and checks it against a per-register scoreboard for RAW/WAW hazards. It then issues the instruction to the lane array in VLEN/VLANES beats, with elements 1–16 first and 17–32 second. It tracks lane writeback so that later instructions are released as soon as their operands are valid.

## Interface
Parameters:
- VLEN, 32: elements per vector register.
- VLANES, 16: lanes; beats per instruction = VLEN/VLANES = 2.
- NREG, 4: vector registers tracked by the scoreboard (V1–V4 mapped to index 0–3).
- WB_LAT, 2: cycles from lane_valid to the matching wb_valid (range 1–7).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_valid  in  1  instruction offered.
- inst_ready  out  1  sequencer can accept; high only in IDLE.
- inst  in  32  instruction word.
- lane_valid  out  1  beat issued to lanes this cycle.
- lane_beat  out  1  0 = elements 1–16, 1 = elements 17–32.
- lane_op  out  3  funct3 of issued instruction.
- lane_vs1, lane_vs2, lane_vd  out  2 each  register indices.
- wb_valid  out  1  lane writeback of one beat completes this cycle.
- wb_vd  out  2  destination of that writeback.
- wb_beat  out  1  beat of that writeback.
- illegal  out  1  one-cycle pulse: accepted word was rejected.
- f_d_cycle  out  3  current state encoding.
- busy_vec  out  NREG  scoreboard contents.
- issue_cnt, stall_cnt  out  16 each  performance counters (see Configuration).

## Operation
- Decode: opcode inst[6:0] must be 7'b1010111, and inst[11:9], inst[19:17], inst[24:22] must all be 0. Fields: vd = inst[8:7], vs1 = inst[16:15], vs2 = inst[21:20], op = inst[14:12].
- A word that fails decode is still consumed on the handshake, then dropped. illegal pulses the next cycle, state stays IDLE, and the scoreboard is untouched.
- States (f_d_cycle value):
  - IDLE (0): inst_ready=1. On inst_valid, latch fields and go to CHECK if legal, otherwise stay in IDLE.
  - CHECK (1): hazard = busy[vs1] | busy[vs2] | busy[vd], using the registered scoreboard. If hazard, stay in CHECK (stall); otherwise go to ISSUE0.
  - ISSUE0 (2): lane_valid=1, lane_beat=0. Set busy[vd]. Go to ISSUE1.
  - ISSUE1 (3): lane_valid=1, lane_beat=1. Go to IDLE.
- Writeback tracking: a WB_LAT-deep shift pipe of {valid, vd, beat} captures every issued beat. Its output drives wb_valid/wb_vd/wb_beat.
- busy[vd] clears on the cycle wb_valid and wb_beat=1 are both high.
- Set and clear of the same register never coincide, because the WAW check forbids issuing to a busy vd.
- Set and clear of different registers in the same cycle both take effect.
- lane_* fields hold their last values when lane_valid=0.

## Timing
- Reset values: state IDLE, inst_ready=1, lane_valid=0, lane_beat=0, lane_op/vs1/vs2/vd=0, wb pipe empty (wb_valid=0, wb_vd=0, wb_beat=0), illegal=0, busy_vec=0, counters=0, f_d_cycle=0.
- Handshake: a transfer occurs when inst_valid & inst_ready. inst_valid may drop without a transfer.
- Hazard-free latency with the handshake at cycle t:
  - CHECK at t+1.
  - Beats at t+2 and t+3.
  - busy visible from t+3.
  - wb beats at t+2+WB_LAT and t+3+WB_LAT.
  - busy cleared and visible from t+4+WB_LAT.
  - inst_ready again at t+4.
- Throughput: at most one instruction per 4 cycles.
- Mid-operation rst: abandons the current instruction, flushes the wb pipe (pending writebacks are never reported), and clears the scoreboard.

## Configuration
- VSEQ_PERF_CNT_EN defined: two saturating counters at 16'hFFFF.
  - issue_cnt increments on each ISSUE0 cycle.
  - stall_cnt increments on each CHECK cycle where a hazard is present.
- Not defined: counters are not built, and issue_cnt and stall_cnt are tied to 0.

## Test plan
- Legal op, vd=1, vs1=2, vs2=3, WB_LAT=2, handshake at cycle 0:
  - lane_valid at cycles 2 and 3 with beat 0 then 1.
  - wb_valid at cycles 4 and 5.
  - busy_vec=4'b0010 during cycles 3–5, 0 from cycle 6.
  - inst_ready high at cycle 4.
- RAW pair: second instruction reads vd=1 and is accepted at cycle 4:
  - stalls in CHECK at cycle 5.
  - ISSUE0 at cycle 7.
  - stall_cnt=1 (with macro).
- Independent pair (disjoint registers) back to back: no stall; second ISSUE0 at cycle 6.
- Bad opcode 7'h33 offered:
  - accepted, illegal pulses 1 cycle later.
  - no lane_valid, busy_vec unchanged.
- rst asserted at cycle 3 (during ISSUE1):
  - the next cycle shows IDLE, busy_vec=0, wb_valid=0 thereafter.
- WAW: two writes to vd=0 back to back; the second issues only after the first's beat-1 writeback clears busy.
